// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bit map, NOP encoding and the ID/EX data record.
package pipe_pkg;

    localparam int CTRL_W         = 12;
    localparam int CTRL_MEMREAD   = 0;
    localparam int CTRL_REGWRITE  = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_BRANCH    = 3;
    localparam int CTRL_ALUOP_LSB = 4;
    localparam int CTRL_ALUOP_W   = 4;

    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
    localparam logic [4:0]        REG_ZERO = 5'd0;

    // Operand/index fields carried from decode into execute.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ex_data_t;

    function automatic logic [CTRL_ALUOP_W-1:0] ctrl_aluop(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_ALUOP_LSB +: CTRL_ALUOP_W];
    endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use detector: a load in EX whose destination is a live source of the decode instruction.
module hazard_unit
    import pipe_pkg::*;
(
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rs_i,
    input  logic       id_uses_rt_i,
    output logic       load_use_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = id_uses_rs_i & (id_rs_i == ex_rd_i);
    assign rt_match = id_uses_rt_i & (id_rt_i == ex_rd_i);

    // $0 is hardwired, so a load targeting it never produces a dependency.
    assign load_use_o = ex_valid_i & ex_memread_i & id_valid_i &
                        (ex_rd_i != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX hold and flush.
// Optional ID_EX_PERF_EN adds a saturating load-use stall counter on stall_cnt.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = pipe_pkg::CTRL_W
`ifdef ID_EX_PERF_EN
    ,
    parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [31:0]       id_rdata1,
    input  logic [31:0]       id_rdata2,
    input  logic [31:0]       id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_hold,
    input  logic              ex_flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
`ifdef ID_EX_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic [CTRL_W-1:0] ex_ctrl
);

    logic              ex_valid_q, ex_valid_d;
    ex_data_t          ex_data_q,  ex_data_d;
    logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
    logic              load_use;

    hazard_unit u_hazard (
        .ex_valid_i   (ex_valid_q),
        .ex_memread_i (ex_ctrl_q[CTRL_MEMREAD]),
        .ex_rd_i      (ex_data_q.rd),
        .id_valid_i   (id_valid),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_uses_rs_i (id_uses_rs),
        .id_uses_rt_i (id_uses_rt),
        .load_use_o   (load_use)
    );

    // A flushed decode instruction is discarded anyway, so it need not hold IF/ID.
    assign id_stall = ex_hold | (load_use & ~ex_flush);

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_data_d  = ex_data_q;
        ex_ctrl_d  = ex_ctrl_q;
        if (ex_hold) begin
            ex_valid_d = ex_valid_q;
        end else if (ex_flush | load_use) begin
            // Bubble: only the valid bit and control are cleared; data stays as-is.
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
        end else begin
            ex_valid_d   = id_valid;
            ex_data_d.pc = id_pc;
            ex_data_d.a  = id_rdata1;
            ex_data_d.b  = id_rdata2;
            ex_data_d.imm = id_imm;
            ex_data_d.rs = id_rs;
            ex_data_d.rt = id_rt;
            ex_data_d.rd = id_rd;
            ex_ctrl_d    = id_valid ? id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_q <= 1'b0;
            ex_data_q  <= '0;
            ex_ctrl_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_data_q  <= ex_data_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign ex_pc    = ex_data_q.pc;
    assign ex_a     = ex_data_q.a;
    assign ex_b     = ex_data_q.b;
    assign ex_imm   = ex_data_q.imm;
    assign ex_rs    = ex_data_q.rs;
    assign ex_rt    = ex_data_q.rt;
    assign ex_rd    = ex_data_q.rd;
    assign ex_ctrl  = ex_ctrl_q;

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counts only edges that actually insert a load-use bubble.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_use & ~ex_flush & ~ex_hold & ~(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scenarios followed by randomized traffic against a slot-level reference model of id_ex_stage.
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              id_valid = 1'b0;
    logic [31:0]       id_pc = '0;
    logic [4:0]        id_rs = '0, id_rt = '0, id_rd = '0;
    logic              id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic [31:0]       id_rdata1 = '0, id_rdata2 = '0, id_imm = '0;
    logic [CTRL_W-1:0] id_ctrl = '0;
    logic              ex_hold = 1'b0, ex_flush = 1'b0;
    logic              id_stall, ex_valid;
    logic [31:0]       ex_pc, ex_a, ex_b, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
`ifdef ID_EX_PERF_EN
    logic [31:0]       stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .ex_hold(ex_hold), .ex_flush(ex_flush),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
`ifdef ID_EX_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .ex_ctrl(ex_ctrl)
    );

    // Reference model: the instruction currently occupying the EX slot.
    typedef struct {
        bit          valid;
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rs, rt, rd;
        logic [11:0] ctrl;
    } slot_t;

    slot_t       m;
    logic [31:0] m_cnt;

    localparam logic [11:0] C_LW  = 12'h021;
    localparam logic [11:0] C_ADD = 12'h012;

    task automatic model_reset();
        m = '{valid: 1'b0, pc: '0, a: '0, b: '0, imm: '0, rs: '0, rt: '0, rd: '0, ctrl: '0};
        m_cnt = '0;
    endtask

    function automatic bit model_load_use();
        bit is_load = m.valid && m.ctrl[CTRL_MEMREAD];
        bit dep = (id_uses_rs && id_rs == m.rd) || (id_uses_rt && id_rt == m.rd);
        return is_load && id_valid && (m.rd != 0) && dep;
    endfunction

    function automatic bit model_stall();
        return ex_hold || (model_load_use() && !ex_flush);
    endfunction

    task automatic model_edge();
        bit lu = model_load_use();
        if (lu && !ex_flush && !ex_hold && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (ex_hold) begin
            // slot unchanged
        end else if (ex_flush || lu) begin
            m.valid = 1'b0;
            m.ctrl  = '0;
        end else begin
            m.valid = id_valid;
            m.pc = id_pc; m.a = id_rdata1; m.b = id_rdata2; m.imm = id_imm;
            m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
            m.ctrl = id_valid ? id_ctrl : 12'h000;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":ex_valid"}, 32'(ex_valid), 32'(m.valid));
        chk({tag, ":ex_ctrl"},  32'(ex_ctrl),  32'(m.ctrl));
        chk({tag, ":ex_pc"},    ex_pc,  m.pc);
        chk({tag, ":ex_a"},     ex_a,   m.a);
        chk({tag, ":ex_b"},     ex_b,   m.b);
        chk({tag, ":ex_imm"},   ex_imm, m.imm);
        chk({tag, ":ex_rs"},    32'(ex_rs), 32'(m.rs));
        chk({tag, ":ex_rt"},    32'(ex_rt), 32'(m.rt));
        chk({tag, ":ex_rd"},    32'(ex_rd), 32'(m.rd));
`ifdef ID_EX_PERF_EN
        chk({tag, ":stall_cnt"}, stall_cnt, m_cnt);
`endif
    endtask

    // One clock: id_stall checked mid-cycle, registered outputs checked just after the edge.
    // exp_stall < 0 means no directed expectation beyond the model.
    task automatic tick(input string tag, input int exp_stall);
        @(negedge clk);
        assert (!(ex_hold && ex_flush)) else begin
            failures++;
            $error("FAIL protocol hold_and_flush observed=1 expected=0");
        end
        chk({tag, ":id_stall"}, 32'(id_stall), 32'(model_stall()));
        if (exp_stall >= 0) chk({tag, ":id_stall_dir"}, 32'(id_stall), 32'(exp_stall));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic set_id(input bit v, input logic [31:0] pc, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input bit urs,
                          input bit urt, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [11:0] ctrl);
        id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt;
        id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; id_ctrl = ctrl;
    endtask

    logic [31:0] saved_pc, saved_a;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: reset while the slot is valid and held clears everything immediately.
        set_id(1, 32'h100, 1, 2, 4, 1, 1, 32'h11, 32'h22, 32'h33, C_ADD);
        tick("t1_fill", 0);
        chk("t1_pre_valid", 32'(ex_valid), 32'd1);
        ex_hold = 1'b1;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_outputs("t1_reset");
        chk("t1_reset_valid", 32'(ex_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        ex_hold = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        tick("t1_after", 0);

        // 2: plain capture.
        set_id(1, 32'h200, 1, 2, 3, 1, 1, 32'h0000_1234, 32'hDEAD_BEEF, 32'h5, C_ADD);
        tick("t2", 0);
        chk("t2_a", ex_a, 32'h0000_1234);
        chk("t2_b", ex_b, 32'hDEAD_BEEF);
        chk("t2_rd", 32'(ex_rd), 32'd3);

        // 3: load-use costs exactly one bubble.
        set_id(1, 32'h300, 1, 2, 5, 1, 0, 32'h1, 32'h2, 32'h8, C_LW);
        tick("t3_lw", 0);
        set_id(1, 32'h304, 5, 6, 7, 1, 1, 32'hA, 32'hB, 32'h0, C_ADD);
        tick("t3_bubble", 1);
        chk("t3_bubble_valid", 32'(ex_valid), 32'd0);
        chk("t3_bubble_ctrl", 32'(ex_ctrl), 32'd0);
        tick("t3_capture", 0);
        chk("t3_capture_pc", ex_pc, 32'h304);
`ifdef ID_EX_PERF_EN
        chk("t3_cnt", stall_cnt, 32'd1);
`endif

        // 4: $0 destination and unused rt never stall.
        set_id(1, 32'h400, 1, 2, 0, 1, 0, 32'h1, 32'h2, 32'h0, C_LW);
        tick("t4_lw0", 0);
        set_id(1, 32'h404, 0, 3, 7, 1, 1, 32'h3, 32'h4, 32'h0, C_LW);
        tick("t4_rs0", 0);
        chk("t4_rs0_valid", 32'(ex_valid), 32'd1);
        set_id(1, 32'h408, 1, 7, 9, 0, 0, 32'h5, 32'h6, 32'h0, C_ADD);
        tick("t4_rt_unused", 0);
        chk("t4_rt_pc", ex_pc, 32'h408);

        // 5: three-cycle hold freezes the slot.
        saved_pc = ex_pc;
        saved_a  = ex_a;
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 32'h500 + 32'(i), 2, 3, 4, 1, 1, $urandom, $urandom, $urandom, C_ADD);
            tick("t5_hold", 1);
            chk("t5_pc_frozen", ex_pc, saved_pc);
            chk("t5_a_frozen", ex_a, saved_a);
        end
        ex_hold = 1'b0;
        tick("t5_release", 0);
        chk("t5_release_pc", ex_pc, 32'h502);

        // 6: flush overrides a load-use.
        set_id(1, 32'h600, 1, 2, 9, 1, 1, 32'h1, 32'h2, 32'h0, C_LW);
        tick("t6_lw", 0);
        set_id(1, 32'h604, 9, 1, 3, 1, 1, 32'h1, 32'h2, 32'h0, C_ADD);
        ex_flush = 1'b1;
        tick("t6_flush", 0);
        chk("t6_flush_valid", 32'(ex_valid), 32'd0);
        ex_flush = 1'b0;
`ifdef ID_EX_PERF_EN
        chk("t6_cnt", stall_cnt, 32'd1);
`endif

        // Randomized traffic with small register indices to provoke dependencies.
        for (int i = 0; i < 400; i++) begin
            int h;
            set_id($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                   $urandom, $urandom, $urandom, 12'($urandom));
            h = $urandom_range(0, 7);
            ex_hold  = (h == 0);
            ex_flush = (h == 1);
            tick("rand", -1);
        end
        ex_hold = 1'b0;
        ex_flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
